csi2_raw10_unpacker: RTL

Converts the RAW10 packet payload stream from the CSI-2 packet handler into parallel 10-bit pixels. Input is the 32-bit byte stream the handler emits: long-packet payload only, `tlast` on the final beat, `tstrb` marking valid bytes. Output is an AXI4-Stream of four pixels per beat, one beat per 5-byte RAW10 group, with `tlast` marking end of line. The block sits directly downstream of the packet handler and feeds the video pipeline.

---
 rtl/csi2_raw10_unpacker.sv | 116 +++++++++++
 1 files changed

// File: rtl/csi2_raw10_unpacker.sv
// rtl/csi2_raw10_unpacker.sv - RAW10 byte stream to 4-pixel beats unpacker
module csi2_raw10_unpacker (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic [31:0] pkt_i_tdata,
  input  logic [3:0]  pkt_i_tstrb,
  input  logic        pkt_i_tvalid,
  input  logic        pkt_i_tlast,
  output logic        pkt_i_tready,
  output logic [39:0] pkt_o_tdata,
  output logic [4:0]  pkt_o_tstrb,
  output logic [4:0]  pkt_o_tkeep,
  output logic        pkt_o_tvalid,
  output logic        pkt_o_tlast,
  output logic        pkt_o_tid,
  output logic        pkt_o_tdest,
  output logic        pkt_o_tuser,
  input  logic        pkt_o_tready,
  output logic        len_err_o
);

  // Byte staging buffer: at most 3 leftover bytes plus one 4-byte beat.
  logic [7:0]  byte_buf [8];
  logic [7:0]  buf_next [8];
  logic [3:0]  byte_cnt;
  logic [3:0]  cnt_next;
  logic [3:0]  base;
  logic [3:0]  nbytes;
  logic        last_pend;
  logic        push;
  logic        pop;
  logic        eol_flush;
  logic [39:0] group_pix;

  assign pkt_o_tstrb = 5'h1f;
  assign pkt_o_tkeep = 5'h1f;
  assign pkt_o_tid   = 1'b0;
  assign pkt_o_tdest = 1'b0;
  assign pkt_o_tuser = 1'b0;

  // tstrb is contiguous from bit 0, so its popcount is the byte count.
  assign nbytes = {3'b000, pkt_i_tstrb[0]} + {3'b000, pkt_i_tstrb[1]}
                + {3'b000, pkt_i_tstrb[2]} + {3'b000, pkt_i_tstrb[3]};

  assign pop          = (byte_cnt >= 4'd5) && (!pkt_o_tvalid || pkt_o_tready);
  assign pkt_i_tready = srst_n_i && !last_pend && ((byte_cnt <= 4'd4) || pop);
  assign push         = pkt_i_tvalid && pkt_i_tready;
  // A pending line end with less than a full group left: drop the residue.
  assign eol_flush    = last_pend && (byte_cnt < 4'd5);

  // Next buffer contents: shift out a popped group, then append the new beat.
  always_comb begin
    for (int k = 0; k < 8; k++) buf_next[k] = byte_buf[k];
    base = byte_cnt;
    if (pop) begin
      base = byte_cnt - 4'd5;
      for (int k = 0; k < 3; k++) buf_next[k] = byte_buf[k + 5];
      for (int k = 3; k < 8; k++) buf_next[k] = 8'h00;
    end
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        if (4'(k) < nbytes) buf_next[3'(base + 4'(k))] = pkt_i_tdata[8*k +: 8];
      end
    end
    cnt_next = base + (push ? nbytes : 4'd0);
  end

  // RAW10 group decode: pixel i is byte i as MSBs and two LSBs from byte 4.
  always_comb begin
    group_pix = '0;
    for (int i = 0; i < 4; i++) begin
      group_pix[10*i +: 10] = {byte_buf[i], byte_buf[4][2*i +: 2]};
    end
  end

  // Buffer, fill level, line-end tracking and length error pulse.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      for (int k = 0; k < 8; k++) byte_buf[k] <= 8'h00;
      byte_cnt  <= 4'd0;
      last_pend <= 1'b0;
      len_err_o <= 1'b0;
    end else begin
      byte_buf <= buf_next;
      if (eol_flush) begin
        byte_cnt  <= 4'd0;
        last_pend <= 1'b0;
        len_err_o <= (byte_cnt != 4'd0);
      end else begin
        byte_cnt  <= cnt_next;
        len_err_o <= 1'b0;
        if (push && pkt_i_tlast) begin
          last_pend <= 1'b1;
        end else if (pop && last_pend && (byte_cnt == 4'd5)) begin
          last_pend <= 1'b0;
        end
      end
    end
  end

  // Output register: loads a decoded group on pop, holds while stalled.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      pkt_o_tvalid <= 1'b0;
      pkt_o_tdata  <= '0;
      pkt_o_tlast  <= 1'b0;
    end else if (pop) begin
      pkt_o_tvalid <= 1'b1;
      pkt_o_tdata  <= group_pix;
      pkt_o_tlast  <= last_pend && (byte_cnt == 4'd5);
    end else if (pkt_o_tready) begin
      pkt_o_tvalid <= 1'b0;
    end
  end

endmodule
